// File: rtl/id_scoreboard.sv
// id_scoreboard: register-hazard scoreboard and issue controller for the decode
// stage of the 5-stage RV32I pipeline. Counts in-flight writes per architectural
// register, gates issue on source/destination hazards and sequences drains.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   issue_valid              decode has an instruction to issue
//   issue_ready              issue permitted this cycle (combinational)
//   rs1/rs1_used, rs2/rs2_used  source registers and their use flags
//   rd/rd_wen                destination register and write enable
//   wb_en/wb_rd              writeback retirement of a pending write
//   kill_en/kill_rd          flushed in-flight writer dropped
//   drain_req                level request to quiesce, held until drain_done
//   drain_done               all counters zero while draining
//   pend_total               registered total of outstanding writes
//   err                      sticky retire/kill against a zero counter
module id_scoreboard #(
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned NREG     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    input  logic [4:0] rd,
    input  logic       rd_wen,
    input  logic       wb_en,
    input  logic [4:0] wb_rd,
    input  logic       kill_en,
    input  logic [4:0] kill_rd,
    input  logic       drain_req,
    output logic       drain_done,
    output logic [7:0] pend_total,
    output logic       err
);

    localparam int unsigned CW  = $clog2(MAX_PEND + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned RW  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   cnt     [NREG];
    logic [CW-1:0]   cnt_nxt [NREG];
    logic [CW1-1:0]  base;
    logic [CW1-1:0]  dec;
    logic            underflow;
    logic [7:0]      total_nxt;
    logic            all_zero_nxt;

    logic            wb_hit_rs1;
    logic            wb_hit_rs2;
    logic            rs1_blk;
    logic            rs2_blk;
    logic            rd_blk;
    logic            fire;

    // Source hazards: the regfile writes through, so a same-cycle retirement
    // removes one pending writer from the count seen by decode.
    assign wb_hit_rs1 = wb_en && (wb_rd == rs1);
    assign wb_hit_rs2 = wb_en && (wb_rd == rs2);
    assign rs1_blk = rs1_used && (rs1 != '0) && (cnt[rs1] > (wb_hit_rs1 ? CW'(1) : CW'(0)));
    assign rs2_blk = rs2_used && (rs2 != '0) && (cnt[rs2] > (wb_hit_rs2 ? CW'(1) : CW'(0)));

    // Destination counter full, unless a same-cycle retire or kill frees a slot.
    assign rd_blk = rd_wen && (rd != '0) && (cnt[rd] == CW'(MAX_PEND))
                    && !(wb_en && (wb_rd == rd)) && !(kill_en && (kill_rd == rd));

    assign issue_ready = !rs1_blk && !rs2_blk && !rd_blk && (state == IDLE) && !drain_req;
    assign fire        = issue_valid && issue_ready;
    assign drain_done  = (state == DONE);

    // Next counter values: +1 issue, -1 writeback, -1 kill, saturating at zero.
    always_comb begin
        cnt_nxt      = cnt;
        base         = '0;
        dec          = '0;
        underflow    = 1'b0;
        total_nxt    = '0;
        all_zero_nxt = 1'b1;
        for (int unsigned r = 1; r < NREG; r++) begin
            base = {1'b0, cnt[r]} + ((fire && rd_wen && (rd == RW'(r))) ? CW1'(1) : CW1'(0));
            dec  = CW1'(2'(wb_en && (wb_rd == RW'(r))) + 2'(kill_en && (kill_rd == RW'(r))));
            if (base < dec) begin
                underflow  = 1'b1;
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = CW'(base - dec);
            end
            total_nxt = total_nxt + 8'(cnt_nxt[r]);
            if (cnt_nxt[r] != '0) begin
                all_zero_nxt = 1'b0;
            end
        end
    end

    // Counter storage, total and sticky error; cnt[0] stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            pend_total <= '0;
            err        <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            pend_total <= total_nxt;
            err        <= err | underflow;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next state: completion uses next-cycle counter values so
    // drain_done rises the cycle after the final retirement.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (drain_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_nxt = IDLE;
                end else if (all_zero_nxt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!drain_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: per-cycle vectors with expected
// issue_ready during the cycle and registered outputs after the edge.
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic [4:0] rd;
    logic       rd_wen;
    logic       wb_en;
    logic [4:0] wb_rd;
    logic       kill_en;
    logic [4:0] kill_rd;
    logic       drain_req;
    logic       drain_done;
    logic [7:0] pend_total;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    id_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs1_used    (rs1_used),
        .rs2         (rs2),
        .rs2_used    (rs2_used),
        .rd          (rd),
        .rd_wen      (rd_wen),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .kill_en     (kill_en),
        .kill_rd     (kill_rd),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .pend_total  (pend_total),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       wb;
        logic [4:0] wbrd;
        logic       kl;
        logic [4:0] klrd;
        logic       dr;
        logic       e_rdy;
        logic [7:0] e_tot;
        logic       e_err;
        logic       e_done;
    } vec_t;

    localparam int NV = 31;
    localparam int N1 = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(input int iv, input int r1, input int u1, input int r2, input int u2,
                                input int d, input int wen, input int wb, input int wbrd,
                                input int kl, input int klrd, input int dr,
                                input int e_rdy, input int e_tot, input int e_err, input int e_done);
        vec_t v;
        v.iv = 1'(iv);   v.rs1 = 5'(r1);  v.u1 = 1'(u1);   v.rs2 = 5'(r2);  v.u2 = 1'(u2);
        v.rd = 5'(d);    v.wen = 1'(wen); v.wb = 1'(wb);   v.wbrd = 5'(wbrd);
        v.kl = 1'(kl);   v.klrd = 5'(klrd); v.dr = 1'(dr);
        v.e_rdy = 1'(e_rdy); v.e_tot = 8'(e_tot); v.e_err = 1'(e_err); v.e_done = 1'(e_done);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; rs1 = '0; rs1_used = 1'b0; rs2 = '0; rs2_used = 1'b0;
        rd = '0; rd_wen = 1'b0; wb_en = 1'b0; wb_rd = '0; kill_en = 1'b0; kill_rd = '0;
        drain_req = 1'b0;
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        issue_valid = vecs[i].iv;  rs1 = vecs[i].rs1; rs1_used = vecs[i].u1;
        rs2 = vecs[i].rs2;         rs2_used = vecs[i].u2;
        rd = vecs[i].rd;           rd_wen = vecs[i].wen;
        wb_en = vecs[i].wb;        wb_rd = vecs[i].wbrd;
        kill_en = vecs[i].kl;      kill_rd = vecs[i].klrd;
        drain_req = vecs[i].dr;
        #1;
        chk("issue_ready", i, 8'(issue_ready), 8'(vecs[i].e_rdy));
        @(posedge clk);
        #1;
        chk("pend_total", i, pend_total, vecs[i].e_tot);
        chk("err", i, 8'(err), 8'(vecs[i].e_err));
        chk("drain_done", i, 8'(drain_done), 8'(vecs[i].e_done));
    endtask

    initial begin
        //            iv r1 u1 r2 u2 rd wen wb wbrd kl klrd dr | rdy tot err done
        // RAW hazard on x5, cleared by same-cycle writeback
        vecs[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[1]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[2]  = mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 0, 0, 0);
        // rs2 hazard and the rs2_used qualifier
        vecs[3]  = mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0,  1, 0, 0, 0);
        // Destination counter saturation on x7
        vecs[7]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 2, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 3, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  0, 3, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0, 0,  1, 3, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7, 0,  1, 3, 0, 0);
        // Source still blocked with count 3 minus one retirement
        vecs[13] = mk(1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 2, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  1, 1, 0, 0);
        vecs[15] = mk(1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  1, 0, 0, 0);
        // x0 never tracked
        vecs[16] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        // wb and kill on a count of 1: underflow, sticky err
        vecs[17] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3, 0,  1, 0, 1, 0);
        // Drain to completion (after reset)
        vecs[19] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,  1, 2, 0, 0);
        vecs[21] = mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0);
        vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1,  0, 1, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1,  0, 0, 0, 1);
        vecs[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[26] = mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // Drain aborted with a pending write: no drain_done
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[30] = mk(1, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1, 0, 0, 0);

        // Reset state
        idle_inputs();
        rst = 1'b1;
        #3;
        chk("reset issue_ready", -1, 8'(issue_ready), 8'd1);
        chk("reset pend_total", -1, pend_total, 8'd0);
        chk("reset err", -1, 8'(err), 8'd0);
        chk("reset drain_done", -1, 8'(drain_done), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N1; i++) begin
            apply(i);
        end

        // Asynchronous reset mid-run with a pending write and err set
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; rd = 5'd10; rd_wen = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-reset pend_total", 100, pend_total, 8'd1);
        chk("pre-reset err", 100, 8'(err), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset err", 101, 8'(err), 8'd0);
        chk("async reset pend_total", 101, pend_total, 8'd0);
        chk("async reset issue_ready", 101, 8'(issue_ready), 8'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        for (int i = N1; i < NV; i++) begin
            apply(i);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
